v0_issue: RTL and testbench

Instruction issue stage for the v0 core; the producing end of the execution-unit interface (`unit`, `inst`, `arg1`, `arg2`, `arg1t`, `arg2t`, `argsz`, `imm32`). It accepts 32-bit instruction words from fetch, takes a trailing 32-bit immediate word when one is flagged, and reads operands from its internal 16×32 register file with write-back bypass. It then presents one decoded operation at a time to the execution side under a valid/ready handshake.

---
 rtl/v0_issue.sv | 185 ++++++++++++++++++
 tb/tb_v0_issue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/v0_issue.sv
// v0_issue: instruction issue stage of the v0 core.
//
// Accepts 32-bit instruction words from fetch. When an opcode has its
// immediate flag set, the next accepted word is taken as a 32-bit immediate.
// Operands come from an internal 16x32 register file. A write-back in the
// same cycle is bypassed to the operand read. One decoded operation at a time
// is held in a registered output stage under a valid/ready handshake.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             synchronous abort of pending / half-received issue
//   fetch_valid/word  incoming instruction or immediate word
//   fetch_ready       word accepted this cycle (combinational)
//   issue_valid/ready output handshake toward the execution side
//   unit, inst        unit select and operation within the unit
//   arg1, arg2        operand values
//   arg1t, arg2t      operand types, passed through from the opcode
//   argsz             operand size code (0=8, 1=16, 2=32 bit)
//   imm32             immediate (sign-extended imm8 or trailing word)
//   wb_en/reg/data    register write-back port
//   illegal           one-cycle pulse: an opcode was rejected and dropped
module v0_issue #(
  parameter int         NREG       = 16,
  parameter logic [3:0] RESVD_UNIT = 4'he
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_word,
  output logic        fetch_ready,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [3:0]  unit,
  output logic [3:0]  inst,
  output logic [31:0] arg1,
  output logic [31:0] arg2,
  output logic [1:0]  arg1t,
  output logic [1:0]  arg2t,
  output logic [2:0]  argsz,
  output logic [31:0] imm32,
  input  logic        wb_en,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        illegal
);

  typedef enum logic {S_OP, S_IMM} state_t;

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic is_illegal(input logic [3:0] u, input logic [2:0] sz);
    return (u == RESVD_UNIT) || (sz > 3'd2);
  endfunction

  state_t      state_q;
  logic [31:0] rf_q [NREG];

  // Fields of an opcode waiting for its immediate word
  logic [3:0]  h_unit_q, h_inst_q, h_reg1_q, h_reg2_q;
  logic [1:0]  h_arg1t_q, h_arg2t_q;
  logic [2:0]  h_argsz_q;

  // Registered output stage
  logic        issue_valid_q, illegal_q;
  logic [3:0]  unit_q, inst_q;
  logic [31:0] arg1_q, arg2_q, imm32_q;
  logic [1:0]  arg1t_q, arg2t_q;
  logic [2:0]  argsz_q;

  logic        accept, op_ill, load;
  logic [3:0]  sel_unit, sel_inst, sel_reg1, sel_reg2;
  logic [1:0]  sel_arg1t, sel_arg2t;
  logic [2:0]  sel_argsz;
  logic [31:0] imm32_d, arg1_d, arg2_d;

  assign fetch_ready = !rst && !flush && (!issue_valid_q || issue_ready);
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    sel_unit  = fetch_word[3:0];
    sel_inst  = fetch_word[7:4];
    sel_reg1  = fetch_word[11:8];
    sel_reg2  = fetch_word[15:12];
    sel_arg1t = fetch_word[17:16];
    sel_arg2t = fetch_word[19:18];
    sel_argsz = fetch_word[22:20];
    imm32_d   = sext8(fetch_word[31:24]);
    if (state_q == S_IMM) begin
      // The incoming word is the immediate; everything else was latched earlier
      sel_unit  = h_unit_q;
      sel_inst  = h_inst_q;
      sel_reg1  = h_reg1_q;
      sel_reg2  = h_reg2_q;
      sel_arg1t = h_arg1t_q;
      sel_arg2t = h_arg2t_q;
      sel_argsz = h_argsz_q;
      imm32_d   = fetch_word;
    end
    op_ill = is_illegal(fetch_word[3:0], fetch_word[22:20]);
    load   = accept && ((state_q == S_IMM) || (!fetch_word[23] && !op_ill));
    // Same-cycle write-back wins over the stored register value
    arg1_d = (wb_en && (wb_reg == sel_reg1)) ? wb_data : rf_q[sel_reg1];
    arg2_d = (wb_en && (wb_reg == sel_reg2)) ? wb_data : rf_q[sel_reg2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_OP;
      issue_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      unit_q        <= '0;
      inst_q        <= '0;
      arg1_q        <= '0;
      arg2_q        <= '0;
      arg1t_q       <= '0;
      arg2t_q       <= '0;
      argsz_q       <= '0;
      imm32_q       <= '0;
      h_unit_q      <= '0;
      h_inst_q      <= '0;
      h_reg1_q      <= '0;
      h_reg2_q      <= '0;
      h_arg1t_q     <= '0;
      h_arg2t_q     <= '0;
      h_argsz_q     <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (wb_en) rf_q[wb_reg] <= wb_data;
      if (flush) begin
        state_q       <= S_OP;
        issue_valid_q <= 1'b0;
        illegal_q     <= 1'b0;
      end else begin
        illegal_q <= accept && (state_q == S_OP) && op_ill;
        if (load) begin
          issue_valid_q <= 1'b1;
          unit_q        <= sel_unit;
          inst_q        <= sel_inst;
          arg1_q        <= arg1_d;
          arg2_q        <= arg2_d;
          arg1t_q       <= sel_arg1t;
          arg2t_q       <= sel_arg2t;
          argsz_q       <= sel_argsz;
          imm32_q       <= imm32_d;
        end else if (issue_ready) begin
          issue_valid_q <= 1'b0;
        end
        if (accept) begin
          case (state_q)
            S_OP: begin
              // Rejected opcodes never wait for an immediate
              if (!op_ill && fetch_word[23]) begin
                state_q   <= S_IMM;
                h_unit_q  <= fetch_word[3:0];
                h_inst_q  <= fetch_word[7:4];
                h_reg1_q  <= fetch_word[11:8];
                h_reg2_q  <= fetch_word[15:12];
                h_arg1t_q <= fetch_word[17:16];
                h_arg2t_q <= fetch_word[19:18];
                h_argsz_q <= fetch_word[22:20];
              end
            end
            S_IMM:   state_q <= S_OP;
            default: state_q <= S_OP;
          endcase
        end
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign illegal     = illegal_q;
  assign unit        = unit_q;
  assign inst        = inst_q;
  assign arg1        = arg1_q;
  assign arg2        = arg2_q;
  assign arg1t       = arg1t_q;
  assign arg2t       = arg2t_q;
  assign argsz       = argsz_q;
  assign imm32       = imm32_q;

endmodule

// File: tb/tb_v0_issue.sv
module tb_v0_issue;

  logic        clk, rst, flush, fetch_valid, fetch_ready;
  logic [31:0] fetch_word;
  logic        issue_valid, issue_ready;
  logic [3:0]  unit, inst;
  logic [31:0] arg1, arg2, imm32;
  logic [1:0]  arg1t, arg2t;
  logic [2:0]  argsz;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  v0_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_word(fetch_word), .fetch_ready(fetch_ready),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .unit(unit), .inst(inst), .arg1(arg1), .arg2(arg2),
    .arg1t(arg1t), .arg2t(arg2t), .argsz(argsz), .imm32(imm32),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        vld;
    logic        ill;
    logic [3:0]  unit, inst;
    logic [31:0] a1, a2, imm;
    logic [2:0]  sz;
    logic [1:0]  t1, t2;
  } vec_t;

  typedef struct packed {
    logic [3:0]  unit, inst;
    logic [1:0]  t1, t2;
    logic [2:0]  sz;
    logic [31:0] a1, a2, imm;
  } op_t;

  function automatic logic [31:0] mk(input logic [3:0] u, input logic [3:0] i,
                                     input logic [3:0] r1, input logic [3:0] r2,
                                     input logic [1:0] t1, input logic [1:0] t2,
                                     input logic [2:0] sz, input logic immf,
                                     input logic [7:0] imm8);
    return {imm8, immf, sz, t2, t1, r2, r1, i, u};
  endfunction

  function automatic logic [31:0] rv(input int i);
    return 32'h10000000 + 32'(i) * 32'h111;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic op_t dut_op();
    return '{unit: unit, inst: inst, t1: arg1t, t2: arg2t, sz: argsz,
             a1: arg1, a2: arg2, imm: imm32};
  endfunction

  vec_t vt[7];

  // Reference model state for the randomized phase
  logic [31:0] mrf [16];
  logic        m_pend, m_ev, m_ill;
  logic [31:0] m_pw;
  op_t         m_op;

  function automatic logic m_illegal(input logic [31:0] w);
    return (w[3:0] == 4'he) || (w[22:20] > 3'd2);
  endfunction

  function automatic logic [31:0] m_rd(input logic [3:0] r);
    if (wb_en && wb_reg == r) return wb_data;
    return mrf[r];
  endfunction

  function automatic op_t m_build(input logic [31:0] w, input logic [31:0] imm);
    op_t o;
    o.unit = w[3:0];   o.inst = w[7:4];
    o.t1   = w[17:16]; o.t2   = w[19:18];
    o.sz   = w[22:20];
    o.a1   = m_rd(w[11:8]);
    o.a2   = m_rd(w[15:12]);
    o.imm  = imm;
    return o;
  endfunction

  initial begin
    logic [31:0] w;
    logic        exp_fr, acc, loaded;
    op_t         nop;

    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_word = '0;
    issue_ready = 1'b1; wb_en = 1'b0; wb_reg = '0; wb_data = '0;

    // ---- reset state
    tick; tick;
    chk("rst_valid", issue_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_outputs", {unit, inst, arg1, arg2, arg1t, arg2t, argsz, imm32}, 0);
    rst = 1'b0;
    #1 chk("fetch_ready_idle", fetch_ready, 1);

    // ---- write-back then decode
    wb_en = 1'b1; wb_reg = 4'd3; wb_data = 32'h11; tick;
    wb_reg = 4'd5; wb_data = 32'h22; tick;
    wb_en = 1'b0;
    fetch_valid = 1'b1; fetch_word = mk(2, 2, 3, 5, 0, 0, 0, 0, 8'h00); tick;
    fetch_valid = 1'b0;
    chk("dec_valid", issue_valid, 1);
    chk("dec_fields", {unit, inst, arg1, arg2, imm32}, {4'd2, 4'd2, 32'h11, 32'h22, 32'h0});
    tick;
    chk("dec_consumed", issue_valid, 0);

    // ---- preload register file
    wb_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wb_reg = 4'(i); wb_data = rv(i); tick;
    end
    wb_en = 1'b0;

    // ---- table-driven single-word decode
    vt[0] = '{mk(1, 3, 2, 7, 1, 2, 2, 0, 8'h80), 1, 0, 4'd1, 4'd3, rv(2), rv(7), 32'hffffff80, 3'd2, 2'd1, 2'd2};
    vt[1] = '{mk(5, 0, 15, 0, 3, 0, 1, 0, 8'h7f), 1, 0, 4'd5, 4'd0, rv(15), rv(0), 32'h7f, 3'd1, 2'd3, 2'd0};
    vt[2] = '{mk(4'he, 1, 1, 1, 0, 0, 0, 0, 8'h00), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{mk(2, 0, 0, 0, 0, 0, 5, 0, 8'h00), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4] = '{mk(2, 0, 0, 0, 0, 0, 3, 0, 8'h00), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{mk(4'he, 0, 0, 0, 0, 0, 0, 1, 8'h00), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6] = '{mk(4'hf, 4'hf, 4, 5, 0, 0, 2, 0, 8'hff), 1, 0, 4'hf, 4'hf, rv(4), rv(5), 32'hffffffff, 3'd2, 2'd0, 2'd0};
    for (int k = 0; k < 7; k++) begin
      fetch_valid = 1'b1; fetch_word = vt[k].word; tick;
      fetch_valid = 1'b0;
      chk($sformatf("vec%0d_valid", k), issue_valid, vt[k].vld);
      chk($sformatf("vec%0d_illegal", k), illegal, vt[k].ill);
      if (vt[k].vld)
        chk($sformatf("vec%0d_fields", k),
            {unit, inst, arg1, arg2, imm32, argsz, arg1t, arg2t},
            {vt[k].unit, vt[k].inst, vt[k].a1, vt[k].a2, vt[k].imm, vt[k].sz, vt[k].t1, vt[k].t2});
      tick;
      chk($sformatf("vec%0d_after", k), {issue_valid, illegal}, 0);
    end

    // ---- immediate word after a fetch stall
    fetch_valid = 1'b1; fetch_word = mk(6, 1, 1, 2, 0, 0, 2, 1, 8'h00); tick;
    fetch_valid = 1'b0;
    chk("imm_no_issue_op", issue_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("imm_no_issue_stall", issue_valid, 0);
    end
    fetch_valid = 1'b1; fetch_word = 32'hdeadbeef; tick;
    fetch_valid = 1'b0;
    chk("imm_valid", issue_valid, 1);
    chk("imm_fields", {unit, inst, arg1, arg2, imm32}, {4'd6, 4'd1, rv(1), rv(2), 32'hdeadbeef});
    tick;

    // ---- back-pressure
    issue_ready = 1'b0;
    fetch_valid = 1'b1; fetch_word = mk(7, 1, 0, 0, 0, 0, 0, 0, 8'h01); tick;
    chk("bp_first_valid", {issue_valid, unit, imm32}, {1'b1, 4'd7, 32'h1});
    fetch_word = mk(8, 2, 0, 0, 0, 0, 0, 0, 8'h02);
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_fetch_ready", fetch_ready, 0);
      tick;
      chk("bp_stable", {issue_valid, unit, inst, imm32}, {1'b1, 4'd7, 4'd1, 32'h1});
    end
    issue_ready = 1'b1;
    #1 chk("bp_release_ready", fetch_ready, 1);
    tick;
    fetch_valid = 1'b0;
    chk("bp_next_op", {issue_valid, unit, inst, imm32}, {1'b1, 4'd8, 4'd2, 32'h2});
    tick;
    chk("bp_no_dup", issue_valid, 0);

    // ---- same-cycle write-back bypass
    wb_en = 1'b1; wb_reg = 4'd7; wb_data = 32'h55;
    fetch_valid = 1'b1; fetch_word = mk(3, 0, 7, 7, 0, 0, 0, 0, 8'h00); tick;
    fetch_valid = 1'b0; wb_en = 1'b0;
    chk("bypass", {issue_valid, arg1, arg2}, {1'b1, 32'h55, 32'h55});
    tick;

    // ---- flush while waiting for an immediate
    fetch_valid = 1'b1; fetch_word = mk(9, 0, 0, 0, 0, 0, 0, 1, 8'h00); tick;
    fetch_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_fetch_ready", fetch_ready, 0);
    tick;
    flush = 1'b0;
    fetch_valid = 1'b1; fetch_word = mk(4'ha, 0, 0, 0, 0, 0, 0, 0, 8'h05); tick;
    fetch_valid = 1'b0;
    chk("flush_then_op", {issue_valid, unit, imm32}, {1'b1, 4'ha, 32'h5});
    tick;

    // ---- reset while an operation is held
    issue_ready = 1'b0;
    fetch_valid = 1'b1; fetch_word = mk(1, 1, 2, 2, 1, 1, 1, 0, 8'h33); tick;
    fetch_valid = 1'b0;
    chk("rst_mid_valid", issue_valid, 1);
    rst = 1'b1; tick;
    chk("rst_mid_outputs", {issue_valid, illegal, fetch_ready, unit, inst, arg1, arg2, arg1t, arg2t, argsz, imm32}, 0);
    rst = 1'b0; issue_ready = 1'b1;
    fetch_valid = 1'b1; fetch_word = mk(1, 1, 2, 3, 0, 0, 0, 0, 8'h00); tick;
    fetch_valid = 1'b0;
    chk("rst_clears_rf", {issue_valid, arg1, arg2}, {1'b1, 32'h0, 32'h0});

    // ---- randomized run against the reference model
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    m_pend = 1'b0; m_ev = 1'b0; m_ill = 1'b0; m_pw = '0; m_op = '0;
    for (int c = 0; c < 3000; c++) begin
      w = $urandom;
      w[22:20] = 3'($urandom_range(0, 3));
      w[23] = ($urandom % 4 == 0);
      fetch_word  = w;
      fetch_valid = ($urandom % 4 != 0);
      issue_ready = ($urandom % 3 != 0);
      wb_en       = $urandom % 2;
      wb_reg      = 4'($urandom);
      wb_data     = $urandom;
      flush       = ($urandom % 50 == 0);
      #1;
      exp_fr = !flush && (!m_ev || issue_ready);
      chk("rnd_fetch_ready", fetch_ready, exp_fr);
      acc = fetch_valid && exp_fr;
      m_ill = 1'b0;
      if (flush) begin
        m_ev = 1'b0; m_pend = 1'b0;
      end else begin
        loaded = 1'b0;
        nop = m_op;
        if (acc) begin
          if (m_pend) begin
            nop = m_build(m_pw, fetch_word); loaded = 1'b1; m_pend = 1'b0;
          end else if (m_illegal(fetch_word)) begin
            m_ill = 1'b1;
          end else if (fetch_word[23]) begin
            m_pend = 1'b1; m_pw = fetch_word;
          end else begin
            nop = m_build(fetch_word, {{24{fetch_word[31]}}, fetch_word[31:24]});
            loaded = 1'b1;
          end
        end
        if (loaded) begin
          m_op = nop; m_ev = 1'b1;
        end else if (issue_ready) begin
          m_ev = 1'b0;
        end
      end
      if (wb_en) mrf[wb_reg] = wb_data;
      tick;
      chk("rnd_valid", issue_valid, m_ev);
      chk("rnd_illegal", illegal, m_ill);
      if (m_ev) chk("rnd_op", dut_op(), m_op);
    end
    flush = 1'b0; fetch_valid = 1'b0; wb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
